// File: rtl/peak_event_buf.sv
// peak_event_buf
//   Reassembles a byte stream (high byte first) into 16-bit words of
//   {channel, sample}, keeps a per-channel exponential average and a
//   per-channel peak detector with hysteresis, and queues completed peaks
//   in a show-ahead event FIFO.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     byte_in/valid     serial byte stream; byte_first forces a high byte
//     threshold, hyst   peak threshold and hysteresis, sampled per word
//     sample_*          one-cycle strobe plus held channel/value/average
//     evt_*             FIFO head (show-ahead), pop handshake, occupancy
//     drop_cnt          events lost to a full FIFO (saturating)
//     bad_ch_cnt        words addressed to an unserviced channel (saturating)
//
//   Peak detector, one per channel
//     state    | meaning
//     ST_BELOW | waiting for a sample above threshold
//     ST_ABOVE | tracking the running maximum until a sample drops below
//              | threshold-hyst, which emits {channel, max}

module peak_event_buf #(
    parameter int DATA_W    = 10,
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 8,
    parameter int AVG_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    input  logic                     byte_first,
    input  logic [DATA_W-1:0]        threshold,
    input  logic [DATA_W-1:0]        hyst,
    output logic                     sample_valid,
    output logic [15-DATA_W:0]       sample_ch,
    output logic [DATA_W-1:0]        sample_data,
    output logic [DATA_W-1:0]        sample_avg,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [15-DATA_W:0]       evt_ch,
    output logic [DATA_W-1:0]        evt_peak,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic [7:0]               drop_cnt,
    output logic [7:0]               bad_ch_cnt
);

    localparam int CH_W  = 16 - DATA_W;
    localparam int ACC_W = DATA_W + AVG_SHIFT;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {
        ST_BELOW = 1'b0,
        ST_ABOVE = 1'b1
    } pk_state_t;

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    logic        phase_q;
    logic [7:0]  hi_q;
    logic        word_vld_q;
    logic [15:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= 1'b0;
            hi_q       <= '0;
            word_vld_q <= 1'b0;
            word_q     <= '0;
        end else begin
            word_vld_q <= 1'b0;
            if (byte_valid) begin
                if (!phase_q || byte_first) begin
                    hi_q    <= byte_in;
                    phase_q <= 1'b1;
                end else begin
                    word_q     <= {hi_q, byte_in};
                    word_vld_q <= 1'b1;
                    phase_q    <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Word decode
    // ------------------------------------------------------------------
    logic [CH_W-1:0]   word_ch;
    logic [DATA_W-1:0] word_x;
    logic              ch_ok;
    logic              proc;
    logic              bad;
    logic [DATA_W-1:0] low_thr;

    assign word_ch = word_q[15:DATA_W];
    assign word_x  = word_q[DATA_W-1:0];
    // One extra bit so NUM_CH == 2^CH_W still compares correctly.
    assign ch_ok   = {1'b0, word_ch} < (CH_W+1)'(NUM_CH);
    assign proc    = word_vld_q && ch_ok;
    assign bad     = word_vld_q && !ch_ok;
    assign low_thr = (threshold > hyst) ? (threshold - hyst) : '0;

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    pk_state_t         st_q   [NUM_CH];
    logic [ACC_W-1:0]  acc_q  [NUM_CH];
    logic              seen_q [NUM_CH];
    logic [DATA_W-1:0] max_q  [NUM_CH];

    pk_state_t         sel_st;
    logic [ACC_W-1:0]  sel_acc;
    logic              sel_seen;
    logic [DATA_W-1:0] sel_max;

    always_comb begin
        sel_st   = ST_BELOW;
        sel_acc  = '0;
        sel_seen = 1'b0;
        sel_max  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (word_ch == CH_W'(c)) begin
                sel_st   = st_q[c];
                sel_acc  = acc_q[c];
                sel_seen = seen_q[c];
                sel_max  = max_q[c];
            end
        end
    end

    // Exponential average: both operands widened by one bit so the
    // difference is signed and the arithmetic shift floors.
    logic [ACC_W-1:0]    x_sh;
    logic signed [ACC_W:0] acc_diff;
    logic signed [ACC_W:0] acc_step;
    logic signed [ACC_W:0] acc_sum;
    logic [ACC_W-1:0]    acc_new;

    always_comb begin
        x_sh     = {word_x, {AVG_SHIFT{1'b0}}};
        acc_diff = $signed({1'b0, x_sh}) - $signed({1'b0, sel_acc});
        acc_step = acc_diff >>> AVG_SHIFT;
        acc_sum  = $signed({1'b0, sel_acc}) + acc_step;
        acc_new  = sel_seen ? acc_sum[ACC_W-1:0] : x_sh;
    end

    // Peak detector next state
    pk_state_t         nxt_st;
    logic [DATA_W-1:0] nxt_max;
    logic              push;

    always_comb begin
        nxt_st  = sel_st;
        nxt_max = sel_max;
        push    = 1'b0;
        case (sel_st)
            ST_BELOW: begin
                if (word_x > threshold) begin
                    nxt_st  = ST_ABOVE;
                    nxt_max = word_x;
                end
            end
            ST_ABOVE: begin
                if (word_x < low_thr) begin
                    nxt_st = ST_BELOW;
                    push   = proc;
                end else if (word_x > sel_max) begin
                    nxt_max = word_x;
                end
            end
            default: nxt_st = ST_BELOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]   <= ST_BELOW;
                acc_q[c]  <= '0;
                seen_q[c] <= 1'b0;
                max_q[c]  <= '0;
            end
        end else if (proc) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (word_ch == CH_W'(c)) begin
                    st_q[c]   <= nxt_st;
                    acc_q[c]  <= acc_new;
                    seen_q[c] <= 1'b1;
                    max_q[c]  <= nxt_max;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample outputs and bad-channel counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            sample_avg   <= '0;
            bad_ch_cnt   <= '0;
        end else begin
            sample_valid <= proc;
            if (proc) begin
                sample_ch   <= word_ch;
                sample_data <= word_x;
                sample_avg  <= acc_new[ACC_W-1:AVG_SHIFT];
            end
            if (bad && bad_ch_cnt != 8'hFF) begin
                bad_ch_cnt <= bad_ch_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign evt_valid = (evt_count != '0);
    assign full      = (evt_count == (AW+1)'(DEPTH));
    assign pop       = evt_valid && evt_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // where wr_ptr points, so the write lands as the new tail.
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {word_ch, sel_max};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
            drop_cnt  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                evt_count <= evt_count + (AW+1)'(1);
            end else if (!push_ok && pop) begin
                evt_count <= evt_count - (AW+1)'(1);
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Head is forced to zero when empty so outputs read 0 out of reset.
    assign evt_ch   = evt_valid ? mem[rd_ptr][15:DATA_W]  : '0;
    assign evt_peak = evt_valid ? mem[rd_ptr][DATA_W-1:0] : '0;

endmodule

// File: tb/tb_peak_event_buf.sv
module tb_peak_event_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_first;
    logic [9:0] threshold;
    logic [9:0] hyst;
    logic       sample_valid;
    logic [5:0] sample_ch;
    logic [9:0] sample_data;
    logic [9:0] sample_avg;
    logic       evt_valid;
    logic       evt_ready;
    logic [5:0] evt_ch;
    logic [9:0] evt_peak;
    logic [3:0] evt_count;
    logic [7:0] drop_cnt;
    logic [7:0] bad_ch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    peak_event_buf #(
        .DATA_W(10), .NUM_CH(4), .DEPTH(8), .AVG_SHIFT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_first(byte_first),
        .threshold(threshold), .hyst(hyst),
        .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_data(sample_data), .sample_avg(sample_avg),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_ch(evt_ch), .evt_peak(evt_peak), .evt_count(evt_count),
        .drop_cnt(drop_cnt), .bad_ch_cnt(bad_ch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        int          sv;
        int          ch;
        int          data;
        int          avg;
        int          cnt;
        int          bad;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic f);
        byte_in    = b;
        byte_first = f;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_first = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8], 1'b0);
        send_byte(w[7:0], 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pop_check(input string name, input int ch, input int peak);
        check({name, "_valid"}, int'(evt_valid), 1);
        check({name, "_ch"}, int'(evt_ch), ch);
        check({name, "_peak"}, int'(evt_peak), peak);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        byte_in    = '0;
        byte_valid = 1'b0;
        byte_first = 1'b0;
        evt_ready  = 1'b0;
        threshold  = 10'd456;
        hyst       = 10'd16;

        vt[0]  = '{16'h05D0, 1, 1, 464, 464, 0, 0};
        vt[1]  = '{16'h05F4, 1, 1, 500, 468, 0, 0};
        vt[2]  = '{16'h0464, 1, 1, 100, 422, 1, 0};
        vt[3]  = '{16'h0190, 1, 0, 400, 400, 1, 0};
        vt[4]  = '{16'h01E0, 1, 0, 480, 410, 1, 0};
        vt[5]  = '{16'h05D0, 1, 1, 464, 427, 1, 0};
        vt[6]  = '{16'h05BD, 1, 1, 445, 429, 1, 0};
        vt[7]  = '{16'h05B7, 1, 1, 439, 430, 2, 0};
        vt[8]  = '{16'h1400, 0, 1, 439, 430, 2, 1};
        vt[9]  = '{16'h09C8, 1, 2, 456, 456, 2, 1};
        vt[10] = '{16'h0DC9, 1, 3, 457, 457, 2, 1};
        vt[11] = '{16'h0DB8, 1, 3, 440, 454, 2, 1};
        vt[12] = '{16'h0C00, 1, 3,   0, 398, 3, 1};
        vt[13] = '{16'h1000, 0, 3,   0, 398, 3, 2};

        @(negedge clk);
        @(negedge clk);
        check("rst_sample_valid", int'(sample_valid), 0);
        check("rst_sample_avg", int'(sample_avg), 0);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_count", int'(evt_count), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_bad_ch_cnt", int'(bad_ch_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: one word per row, outputs checked the cycle after processing.
        for (int i = 0; i < 14; i++) begin
            send_word(vt[i].word);
            @(negedge clk);
            check($sformatf("v%0d_sv", i), int'(sample_valid), vt[i].sv);
            check($sformatf("v%0d_ch", i), int'(sample_ch), vt[i].ch);
            check($sformatf("v%0d_data", i), int'(sample_data), vt[i].data);
            check($sformatf("v%0d_avg", i), int'(sample_avg), vt[i].avg);
            check($sformatf("v%0d_cnt", i), int'(evt_count), vt[i].cnt);
            check($sformatf("v%0d_evv", i), int'(evt_valid), (vt[i].cnt != 0) ? 1 : 0);
            check($sformatf("v%0d_bad", i), int'(bad_ch_cnt), vt[i].bad);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), int'(sample_valid), 0);
        end

        pop_check("pop0", 1, 500);
        pop_check("pop1", 1, 464);
        pop_check("pop2", 3, 457);
        check("pop_empty_valid", int'(evt_valid), 0);
        check("pop_empty_count", int'(evt_count), 0);

        // Overflow: nine peaks with no consumer.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_word(16'((i % 4) << 10) | 16'(460 + i));
            send_word(16'((i % 4) << 10));
            @(negedge clk);
        end
        check("ovf_count", int'(evt_count), 8);
        check("ovf_drop", int'(drop_cnt), 1);

        // Push while full with a pop on the same edge.
        send_word(16'h0400 | 16'd470);
        send_word(16'h0400);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("fullpp_count", int'(evt_count), 8);
        check("fullpp_drop", int'(drop_cnt), 1);
        for (int i = 1; i < 8; i++) begin
            pop_check($sformatf("ovf_pop%0d", i), i % 4, 460 + i);
        end
        pop_check("ovf_pop_last", 1, 470);
        check("ovf_empty", int'(evt_valid), 0);

        // Reset discards a half-received word.
        send_byte(8'h05, 1'b0);
        do_reset();
        send_word(16'h05D0);
        @(negedge clk);
        check("rsthalf_sv", int'(sample_valid), 1);
        check("rsthalf_ch", int'(sample_ch), 1);
        check("rsthalf_data", int'(sample_data), 464);
        check("rsthalf_avg", int'(sample_avg), 464);

        // Reset discards a word completed but not yet processed.
        send_word(16'h05F4);
        do_reset();
        @(negedge clk);
        check("rstpend_sv", int'(sample_valid), 0);
        check("rstpend_data", int'(sample_data), 0);

        // byte_first resynchronises after a stray high byte.
        send_byte(8'h07, 1'b0);
        send_byte(8'h05, 1'b1);
        send_byte(8'hD0, 1'b0);
        @(negedge clk);
        check("resync_sv", int'(sample_valid), 1);
        check("resync_ch", int'(sample_ch), 1);
        check("resync_data", int'(sample_data), 464);
        check("resync_bad", int'(bad_ch_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/peak_event_buf.md
PEAK_EVENT_BUF -- requirements
Module: peak_event_buf

Interface
REQ-001 Parameter DATA_W, default 10, sample data width; channel field is the upper 16-DATA_W bits of each 16-bit word.
REQ-002 Parameter NUM_CH, default 4, number of serviced channels (channel IDs 0..NUM_CH-1); NUM_CH SHALL NOT exceed 2^(16-DATA_W).
REQ-003 Parameter DEPTH, default 8, event FIFO depth, power of two, at least 2.
REQ-004 Parameter AVG_SHIFT, default 3, exponential-average shift; SHALL be at least 1.
REQ-005 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- byte_in  in  8  serial byte stream, high byte first
- byte_valid  in  1  byte_in valid this cycle
- byte_first  in  1  with byte_valid, forces byte_in to be taken as a high byte
- threshold  in  DATA_W  unsigned peak threshold
- hyst  in  DATA_W  unsigned hysteresis
- sample_valid  out  1  one-cycle strobe, processed sample
- sample_ch  out  16-DATA_W  channel of processed sample
- sample_data  out  DATA_W  processed sample value
- sample_avg  out  DATA_W  channel average after update
- evt_valid  out  1  event FIFO not empty
- evt_ready  in  1  consumer pops the head event
- evt_ch  out  16-DATA_W  head event channel
- evt_peak  out  DATA_W  head event peak value
- evt_count  out  clog2(DEPTH)+1  FIFO occupancy
- drop_cnt  out  8  events lost to a full FIFO, saturating
- bad_ch_cnt  out  8  words with channel >= NUM_CH, saturating

Function
REQ-006 A phase bit SHALL toggle on each accepted byte; a byte accepted with phase 0 or with byte_first=1 SHALL be stored as the high byte, and SHALL set phase to 1.
REQ-007 A byte accepted with phase 1 and byte_first=0 SHALL complete word {high,byte_in} at that edge (edge N) and SHALL return phase to 0.
REQ-008 At edge N+1 the word SHALL be processed; a word with channel >= NUM_CH SHALL only increment bad_ch_cnt (saturating at 255).
REQ-009 A valid word SHALL set sample_valid high for exactly the cycle after edge N+1, with sample_ch/sample_data/sample_avg held until the next processed word.
REQ-010 Each channel SHALL hold an accumulator acc of DATA_W+AVG_SHIFT bits; the first sample after reset SHALL load acc = x<<AVG_SHIFT; later samples SHALL update acc = acc + ((x<<AVG_SHIFT) - acc) >>> AVG_SHIFT, signed, floor rounding; sample_avg = acc>>AVG_SHIFT.
REQ-011 Each channel SHALL run a two-state FSM BELOW/ABOVE, reset to BELOW, with a running maximum register.
REQ-012 BELOW->ABOVE SHALL occur when x > threshold (unsigned), loading max = x.
REQ-013 In ABOVE, a sample x >= low SHALL update max = max(max,x), where low = threshold-hyst saturated at 0.
REQ-014 ABOVE->BELOW SHALL occur when x < low, pushing event {channel, max} at edge N+1.
REQ-015 threshold and hyst SHALL be sampled at edge N+1 of each word.
REQ-016 The event FIFO SHALL be show-ahead: evt_valid = (evt_count != 0); evt_ch/evt_peak present the head; a pop occurs when evt_valid and evt_ready.
REQ-017 A push while full with no simultaneous pop SHALL be dropped, incrementing drop_cnt (saturating at 255).
REQ-018 A push while full with a simultaneous pop SHALL be accepted, leaving evt_count unchanged.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; evt_count SHALL range 0..DEPTH.

Reset
REQ-020 rst_n low SHALL asynchronously clear phase, all accumulators and first-sample flags, all FSMs to BELOW, maxima, FIFO pointers, evt_count, drop_cnt, bad_ch_cnt, sample_valid, and every output to 0.
REQ-021 A partially received word or a pending processing step SHALL be discarded by reset; the first byte after release SHALL be a high byte.

Verification (DATA_W=10, NUM_CH=4, DEPTH=8, AVG_SHIFT=3, threshold=456, hyst=16)
REQ-022 Send bytes 05 D0, 05 F4, 04 64 (ch1: 464, 500, 100) -> single event ch1 peak 500, evt_valid one cycle after last word's edge N+1.
REQ-023 Send ch1 464 then 445 -> no event, since 445 >= low of 440; then 439 -> event ch1 peak 464.
REQ-024 Send ch0 400 then 480 -> sample_avg 400 then 410.
REQ-025 Send word 14 00 (ch5) -> no sample_valid, bad_ch_cnt=1; then 9 peak events with evt_ready=0 -> evt_count=8, drop_cnt=1; pops return events in order.
REQ-026 Send byte 05, assert rst_n low, release, send 05 D0 -> word ch1 464 processed correctly, no stale byte; byte_first=1 mid-word likewise resynchronises.
